// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parameterised FWFT synchronous FIFO; optional misuse flag under FIFO_ERR_CHECK_EN
module param_fifo #(
    parameter int WIDTH    = 17,
    parameter int LG_DEPTH = 8,
    parameter int AF_LEVEL = (2 ** LG_DEPTH) - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                clk,
    input  logic                clear_n_i,
    input  logic                flush_i,
    input  logic [WIDTH-1:0]    data_i,
    input  logic                enque_i,
    input  logic                deque_i,
    output logic [WIDTH-1:0]    data_o,
    output logic                valid_o,
    output logic                empty_o,
    output logic                full_o,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic [LG_DEPTH:0]   count_o,
    output logic                error_o
);

    localparam int DEPTH = 2 ** LG_DEPTH;
    localparam logic [LG_DEPTH:0] AF_THRESH = AF_LEVEL[LG_DEPTH:0];
    localparam logic [LG_DEPTH:0] AE_THRESH = AE_LEVEL[LG_DEPTH:0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // while every storage slot remains usable.
    logic [LG_DEPTH:0]  wptr;
    logic [LG_DEPTH:0]  rptr;
    logic [WIDTH-1:0]   storage [DEPTH];

    logic               is_empty;
    logic               is_full;
    logic               deq_ok;
    logic               enq_ok;

    // Status is derived from the registered pointers only.
    assign is_empty = (wptr == rptr);
    assign is_full  = (wptr[LG_DEPTH] != rptr[LG_DEPTH]) &&
                      (wptr[LG_DEPTH-1:0] == rptr[LG_DEPTH-1:0]);

    // A read on an empty FIFO is dropped; a write on a full FIFO only goes in
    // when the head is leaving in the same cycle.
    assign deq_ok = deque_i && !is_empty;
    assign enq_ok = enque_i && (!is_full || deq_ok);

    assign count_o        = wptr - rptr;
    assign empty_o        = is_empty;
    assign valid_o        = !is_empty;
    assign full_o         = is_full;
    assign almost_full_o  = (count_o >= AF_THRESH);
    assign almost_empty_o = (count_o <= AE_THRESH);

    // First-word-fall-through: the head slot is presented directly.
    assign data_o = storage[rptr[LG_DEPTH-1:0]];

    // Storage array has no reset; only accepted writes land in it.
    always_ff @(posedge clk) begin
        if (clear_n_i && !flush_i && enq_ok) begin
            storage[wptr[LG_DEPTH-1:0]] <= data_i;
        end
    end

    // Pointer update: reset dominates flush, flush dominates traffic.
    always_ff @(posedge clk) begin
        if (!clear_n_i) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (enq_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (deq_ok) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

`ifdef FIFO_ERR_CHECK_EN
    logic err_q;
    logic overflow;
    logic underflow;

    // Flush cycles ignore the request lines, so they cannot be misuse either.
    assign overflow  = !flush_i && enque_i && is_full && !deque_i;
    assign underflow = !flush_i && deque_i && is_empty;

    // Sticky misuse flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!clear_n_i) begin
            err_q <= 1'b0;
        end else if (overflow || underflow) begin
            err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Simulation-only diagnostics for misuse.
    always_ff @(posedge clk) begin
        if (clear_n_i && overflow) begin
            $display("error: wrote full fifo");
        end
        if (clear_n_i && underflow) begin
            $display("error: deque empty fifo");
        end
    end
`endif

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - randomized and directed check of param_fifo against a queue model
module tb_param_fifo;

    localparam int W   = 8;
    localparam int LG  = 3;
    localparam int CAP = 8;
    localparam int AF  = 4;
    localparam int AE  = 4;

    logic          clk = 1'b0;
    logic          clear_n_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          enque_i = 1'b0;
    logic          deque_i = 1'b0;
    logic [W-1:0]  data_o;
    logic          valid_o;
    logic          empty_o;
    logic          full_o;
    logic          almost_full_o;
    logic          almost_empty_o;
    logic [LG:0]   count_o;
    logic          error_o;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] model_q[$];
    logic         model_err = 1'b0;

    param_fifo #(.WIDTH(W), .LG_DEPTH(LG)) dut (
        .clk(clk),
        .clear_n_i(clear_n_i),
        .flush_i(flush_i),
        .data_i(data_i),
        .enque_i(enque_i),
        .deque_i(deque_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .empty_o(empty_o),
        .full_o(full_o),
        .almost_full_o(almost_full_o),
        .almost_empty_o(almost_empty_o),
        .count_o(count_o),
        .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output with what the queue model says.
    task automatic check_all(input string tag);
        int n;
        logic exp_err;
        n = model_q.size();
`ifdef FIFO_ERR_CHECK_EN
        exp_err = model_err;
`else
        exp_err = 1'b0;
`endif
        chk({tag, ".count"}, 32'(count_o), 32'(n));
        chk({tag, ".empty"}, 32'(empty_o), 32'(n == 0));
        chk({tag, ".valid"}, 32'(valid_o), 32'(n != 0));
        chk({tag, ".full"},  32'(full_o),  32'(n == CAP));
        chk({tag, ".af"},    32'(almost_full_o),  32'(n >= AF));
        chk({tag, ".ae"},    32'(almost_empty_o), 32'(n <= AE));
        chk({tag, ".err"},   32'(error_o), 32'(exp_err));
        if (n != 0) begin
            chk({tag, ".data"}, 32'(data_o), 32'(model_q[0]));
        end
    endtask

    // One clock of stimulus; the model applies the FIFO rules to its queue.
    task automatic step(input string tag, input logic e, input logic d,
                        input logic [W-1:0] din, input logic f, input logic c);
        int n;
        logic d_ok;
        logic e_ok;
        enque_i   = e;
        deque_i   = d;
        data_i    = din;
        flush_i   = f;
        clear_n_i = c;
        @(posedge clk);
        n = model_q.size();
        if (!c) begin
            model_q.delete();
            model_err = 1'b0;
        end else if (f) begin
            model_q.delete();
        end else begin
            d_ok = d && (n > 0);
            e_ok = e && ((n < CAP) || d_ok);
            if (e && (n == CAP) && !d) model_err = 1'b1;
            if (d && (n == 0)) model_err = 1'b1;
            if (d_ok) void'(model_q.pop_front());
            if (e_ok) model_q.push_back(din);
        end
        #1;
        enque_i = 1'b0;
        deque_i = 1'b0;
        flush_i = 1'b0;
        clear_n_i = 1'b1;
        check_all(tag);
    endtask

    initial begin
        int pe;
        int pd;
        // Reset state
        step("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Fill with 0x01..0x08 and drain in order
        for (int i = 1; i <= CAP; i++) step("fill", 1'b1, 1'b0, 8'(i), 1'b0, 1'b1);
        chk("fill.full_now", 32'(full_o), 32'd1);
        for (int i = 1; i <= CAP; i++) begin
            chk("drain.head", 32'(data_o), 32'(i));
            step("drain", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        end
        chk("drain.empty_now", 32'(empty_o), 32'd1);

        // Full with simultaneous enque+deque of 0x55
        for (int i = 1; i <= CAP; i++) step("refill", 1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b1);
        step("full_rw", 1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
        chk("full_rw.count8", 32'(count_o), 32'd8);

        // Overflow while full
        step("overflow", 1'b1, 1'b0, 8'hAA, 1'b0, 1'b1);
        for (int i = 0; i < CAP; i++) step("ovf_drain", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

        // Underflow with write on empty
        step("empty_rw", 1'b1, 1'b1, 8'h12, 1'b0, 1'b1);
        chk("empty_rw.data12", 32'(data_o), 32'h12);
        step("empty_rw_pop", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

        // Wrap: 20 write/read pairs
        for (int i = 0; i < 20; i++) begin
            step("wrap_w", 1'b1, 1'b0, 8'(8'h30 + i), 1'b0, 1'b1);
            step("wrap_r", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        end

        // Flush at 5 entries, then reset at 3 entries
        for (int i = 0; i < 5; i++) step("pre_flush", 1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b1);
        step("flush", 1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("pre_clr", 1'b1, 1'b0, 8'(8'h70 + i), 1'b0, 1'b1);
        step("mid_reset", 1'b1, 1'b0, 8'hEF, 1'b0, 1'b0);
        step("post_reset_w", 1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
        chk("post_reset.head", 32'(data_o), 32'h99);

        // Randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 3000; i++) begin
            if (((i / 200) % 2) == 0) begin
                pe = 70; pd = 40;
            end else begin
                pe = 40; pd = 70;
            end
            step("rand",
                 $urandom_range(0, 99) < pe,
                 $urandom_range(0, 99) < pd,
                 8'($urandom_range(0, 255)),
                 $urandom_range(0, 199) == 0,
                 $urandom_range(0, 399) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 17: data word width in bits.
REQ-002 SHALL have parameter LG_DEPTH, default 8: capacity is 2**LG_DEPTH entries; legal range 1..12.
REQ-003 SHALL have parameter AF_LEVEL, default 2**LG_DEPTH-4: almost_full_o asserts when count_o >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 4: almost_empty_o asserts when count_o <= AE_LEVEL.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, all state on rising edge
- clear_n_i  in  1  synchronous active-low reset
- flush_i  in  1  synchronous discard of all entries
- data_i  in  WIDTH  write data
- enque_i  in  1  write request
- deque_i  in  1  read request
- data_o  out  WIDTH  head entry, first-word-fall-through
- valid_o  out  1  head entry valid (= !empty_o)
- empty_o  out  1  count_o == 0
- full_o  out  1  count_o == 2**LG_DEPTH
- almost_full_o  out  1  per REQ-003
- almost_empty_o  out  1  per REQ-004
- count_o  out  LG_DEPTH+1  current occupancy
- error_o  out  1  sticky misuse flag (see Configuration)

Function
REQ-006 SHALL use read/write pointers of LG_DEPTH+1 bits; full when low bits match and MSBs differ, so all 2**LG_DEPTH entries are usable.
REQ-007 SHALL drive data_o combinationally from storage[rptr]; new head visible the cycle after the deque edge, zero extra latency.
REQ-008 SHALL make a write visible on data_o/valid_o the cycle after the enque edge; no same-cycle bypass.
REQ-009 SHALL derive all flags and count_o from registered pointers only; no combinational path from enque_i/deque_i to any flag.
REQ-010 SHALL accept enque_i when not full; SHALL also accept it when full if deque_i is accepted in the same cycle; count unchanged.
REQ-011 SHALL ignore enque_i when full and deque_i is low; pointers and storage unchanged (overflow).
REQ-012 SHALL ignore deque_i when empty, including when enque_i is high; the entry is still written (underflow).
REQ-013 SHALL leave count_o unchanged and advance both pointers on simultaneous accepted enque and deque.
REQ-014 SHALL wrap pointers modulo 2**(LG_DEPTH+1) with no gap or repeated entry.
REQ-015 SHALL make flush_i zero both pointers next cycle, ignoring same-cycle enque_i/deque_i; error_o is unaffected.
REQ-016 SHALL leave data_o undefined while valid_o is low; storage is not reset.

Reset
REQ-017 SHALL, when clear_n_i is low at a rising edge, zero both pointers and error_o; this overrides flush_i, enque_i and deque_i.
REQ-018 SHALL present these values after reset: empty_o=1, valid_o=0, full_o=0, count_o=0, almost_empty_o=1, almost_full_o=0, error_o=0.
REQ-019 SHALL discard all contents on mid-operation reset; the first post-reset write is the next head.

Configuration
REQ-020 SHALL, when macro FIFO_ERR_CHECK_EN is defined, set error_o on any overflow (REQ-011) or underflow (REQ-012); it holds until reset, and simulation prints "error: wrote full fifo" or "error: deque empty fifo".
REQ-021 SHALL, when FIFO_ERR_CHECK_EN is undefined, tie error_o to 0 and omit the check logic and messages; all other behaviour is identical.

Verification
REQ-022 Reset then fill: LG_DEPTH=3, write 0x01..0x08 -> full_o=1, count_o=8, almost_full_o=1; read back 0x01..0x08 in order, then empty_o=1.
REQ-023 Full with simultaneous enque+deque of 0x55 -> head pops, count_o stays 8, full_o stays 1, 0x55 is read out last.
REQ-024 Overflow: 9th write 0xAA while full, deque low -> contents unchanged; error_o=1 with FIFO_ERR_CHECK_EN, 0 without.
REQ-025 Empty with enque 0x12 and deque together -> deque ignored, count_o=1 next cycle, data_o=0x12, error_o=1 if enabled.
REQ-026 Wrap: 20 write/read pairs on LG_DEPTH=3 -> data order preserved across wrap, count_o never exceeds 1.
REQ-027 flush_i at count_o=5, then clear_n_i low at count_o=3 -> count_o=0 after each; error_o survives flush but is cleared by reset.
